// File: rtl/practice_sequencer.sv
// Scale-drill lesson controller: presents one target note per step, scores a
// stable match on note_in as a hit or a LISTEN timeout as a miss.
module practice_sequencer #(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int SEQ_LEN        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] note_in,
  output logic [4:0] target_note,
  output logic [2:0] step,
  output logic [3:0] score,
  output logic       hit,
  output logic       miss,
  output logic       listening,
  output logic       done
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_LISTEN  = 3'd2,
    S_HIT     = 3'd3,
    S_MISS    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      score_q, score_d;
  logic [4:0]      target_q, target_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic            listening_q, listening_d;
  logic            done_q, done_d;
  logic            match;

  // C major scale, C4..C5, in note_Select codes
  function automatic logic [4:0] rom_note(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_note = 5'd1;
      3'd1:    rom_note = 5'd3;
      3'd2:    rom_note = 5'd5;
      3'd3:    rom_note = 5'd6;
      3'd4:    rom_note = 5'd8;
      3'd5:    rom_note = 5'd10;
      3'd6:    rom_note = 5'd12;
      default: rom_note = 5'd13;
    endcase
  endfunction

  assign match = (note_in == target_q);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    score_d    = score_q;
    target_d   = target_q;
    hold_cnt_d = hold_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          step_d   = 3'd0;
          score_d  = 4'd0;
          target_d = rom_note(3'd0);
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (note_in == 5'd0) begin
          hold_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = S_LISTEN;
        end
      end
      S_LISTEN: begin
        hold_cnt_d = match ? hold_cnt_q + 1'b1 : '0;
        tmo_cnt_d  = tmo_cnt_q + 1'b1;
        // a hit landing on the final timeout cycle still counts as a hit
        if (match && hold_cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = S_HIT;
        end else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_MISS;
        end
      end
      S_HIT, S_MISS: begin
        if (state_q == S_HIT) begin
          score_d = score_q + 4'd1;
        end
        if (step_q == 3'(SEQ_LEN - 1)) begin
          target_d = 5'd0;
          state_d  = S_DONE;
        end else begin
          step_d   = step_q + 3'd1;
          target_d = rom_note(step_q + 3'd1);
          state_d  = S_RELEASE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    hit_d       = (state_d == S_HIT);
    miss_d      = (state_d == S_MISS);
    listening_d = (state_d == S_LISTEN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      score_q     <= 4'd0;
      target_q    <= 5'd0;
      hold_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      listening_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      score_q     <= score_d;
      target_q    <= target_d;
      hold_cnt_q  <= hold_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      listening_q <= listening_d;
      done_q      <= done_d;
    end
  end

  assign target_note = target_q;
  assign step        = step_q;
  assign score       = score_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign listening   = listening_q;
  assign done        = done_q;

endmodule

// File: tb/tb_practice_sequencer.sv
// Bench for practice_sequencer: expected hit/miss events are queued as notes
// are driven and matched against the pulses the sequencer produces.
module tb_practice_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] note_in = 5'd0;
  logic [4:0] target_note;
  logic [2:0] step;
  logic [3:0] score;
  logic       hit, miss, listening, done;

  practice_sequencer #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(20), .SEQ_LEN(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .note_in     (note_in),
    .target_note (target_note),
    .step        (step),
    .score       (score),
    .hit         (hit),
    .miss        (miss),
    .listening   (listening),
    .done        (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int is_hit;
    int step;
    int score;
    int len;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   listen_cnt = 0;
  int   last_len = 0;
  int   rom[8] = '{1, 3, 5, 6, 8, 10, 12, 13};

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int is_hit, input int s, input int sc, input int len);
    exp_t e;
    e.is_hit = is_hit;
    e.step   = s;
    e.score  = sc;
    e.len    = len;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_listen();
    for (int i = 0; i < 50 && !listening; i++) tick();
    check("wait_listen", listening, 1);
  endtask

  // scoreboard side: measure LISTEN length and pop an expectation per pulse
  always @(negedge clock) begin
    if (listening) begin
      listen_cnt++;
    end else if (listen_cnt != 0) begin
      last_len   = listen_cnt;
      listen_cnt = 0;
    end
    if (hit || miss) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {hit, miss}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_hit", hit, e.is_hit);
        check("pulse_miss", miss, 1 - e.is_hit);
        check("pulse_step", step, e.step);
        check("pulse_score", score, e.score);
        check("listen_len", last_len, e.len);
      end
    end
  end

  initial begin
    // reset then idle
    reset = 1'b1;
    note_in = 5'd7;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      note_in = 5'(i + 1);
      tick();
    end
    note_in = 5'd0;
    check("idle_state", int'(dut.state_q), 0);
    check("idle_target", target_note, 0);
    check("idle_score", score, 0);
    check("idle_step", step, 0);
    check("idle_done", done, 0);
    check("idle_listen", listening, 0);

    // perfect run
    do_start();
    check("start_state", int'(dut.state_q), 1);
    check("start_target", target_note, rom[0]);
    for (int s = 0; s < 8; s++) begin
      wait_listen();
      check("perfect_target", target_note, rom[s]);
      push(1, s, s, 4);
      note_in = 5'(rom[s]);
      repeat (4) tick();
      note_in = 5'd0;
    end
    for (int i = 0; i < 10 && !done; i++) tick();
    check("perfect_done", done, 1);
    check("perfect_score", score, 8);
    check("perfect_target0", target_note, 0);
    check("perfect_step", step, 7);
    check("perfect_state", int'(dut.state_q), 5);

    // timeout with a wrong note, restarted from DONE
    do_start();
    check("restart_score", score, 0);
    wait_listen();
    note_in = 5'd3;
    push(0, 0, 0, 20);
    repeat (19) tick();
    check("tmo_not_yet", int'(dut.state_q), 2);
    tick();
    check("tmo_state", int'(dut.state_q), 4);
    check("tmo_miss", miss, 1);
    tick();
    check("tmo_miss_width", miss, 0);
    check("tmo_step", step, 1);
    check("tmo_score", score, 0);
    check("tmo_target", target_note, 3);
    // note_in still equals the new target: must stay gated in RELEASE
    repeat (5) tick();
    check("release_gate", int'(dut.state_q), 1);
    check("release_listen", listening, 0);
    note_in = 5'd0;

    // broken hold: 1,1,1,0,1,1,1,1
    do_reset();
    do_start();
    wait_listen();
    push(1, 0, 0, 8);
    for (int i = 0; i < 8; i++) begin
      note_in = (i == 3) ? 5'd0 : 5'd1;
      tick();
      if (i == 6) check("broken_no_early", int'(dut.state_q), 2);
    end
    note_in = 5'd0;
    check("broken_hit", hit, 1);
    tick();
    check("broken_score", score, 1);

    // hit and timeout on the same cycle
    do_reset();
    do_start();
    wait_listen();
    push(1, 0, 0, 20);
    note_in = 5'd2;
    repeat (16) tick();
    note_in = 5'd1;
    repeat (4) tick();
    note_in = 5'd0;
    check("tie_state", int'(dut.state_q), 3);
    check("tie_miss", miss, 0);
    tick();
    check("tie_score", score, 1);
    check("tie_step", step, 1);

    // mid-run reset in LISTEN at step 3
    do_reset();
    do_start();
    for (int s = 0; s < 3; s++) begin
      wait_listen();
      push(1, s, s, 4);
      note_in = 5'(rom[s]);
      repeat (4) tick();
      note_in = 5'd0;
    end
    wait_listen();
    check("mid_step3", step, 3);
    check("mid_score3", score, 3);
    note_in = 5'(rom[3]);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_state", int'(dut.state_q), 0);
    check("rst_step", step, 0);
    check("rst_score", score, 0);
    check("rst_target", target_note, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_listen", listening, 0);
    tick();
    reset = 1'b0;
    note_in = 5'd0;
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
